// File: rtl/ni_route_packer_pkg.sv
// Shared NoC definitions plus the packer's types, widths and flit layouts.
// The flit-format macros are shared with the switch side of the network.
`ifndef NOC_PARAMETERS_V
`define NOC_PARAMETERS_V
`define FTYPEWD 2
`define ROUTEWD 12
`define FT_HEAD 2'b10
`define FT_BODY 2'b00
`define FT_TAIL 2'b01
`define FT_HEADTAIL 2'b11
`define HDR_LEN_OFS (`FTYPEWD+`ROUTEWD)
`endif

package ni_route_packer_pkg;

  localparam int unsigned FLIT_WIDTH  = 32;
  localparam int unsigned L_SW_OUT    = 2;
  localparam int unsigned DEST_NUM    = 8;
  localparam int unsigned DEST_W      = 3;
  localparam int unsigned LEN_W       = 4;
  localparam int unsigned CREDITS     = 4;
  localparam int unsigned FTYPE_W     = `FTYPEWD;
  localparam int unsigned ROUTE_W     = `ROUTEWD;
  localparam int unsigned HDR_LEN_OFS = `HDR_LEN_OFS;
  localparam int unsigned PL_W        = FLIT_WIDTH - FTYPE_W;
  localparam int unsigned MAX_HOPS    = ROUTE_W / L_SW_OUT;
  localparam int unsigned RSVD_W      = FLIT_WIDTH - HDR_LEN_OFS - LEN_W;
  localparam int unsigned CRED_W      = $clog2(CREDITS + 1);

  typedef enum logic [FTYPE_W-1:0] {
    FT_BODY     = `FT_BODY,
    FT_TAIL     = `FT_TAIL,
    FT_HEAD     = `FT_HEAD,
    FT_HEADTAIL = `FT_HEADTAIL
  } ftype_e;

  typedef enum logic {
    ST_IDLE,
    ST_PAYLOAD
  } state_e;

  // Element 0 is the first hop's output-port selector (lowest bits).
  typedef logic [MAX_HOPS-1:0][L_SW_OUT-1:0] route_t;

  typedef struct packed {
    logic [RSVD_W-1:0] rsvd;
    logic [LEN_W-1:0]  len;
    route_t            route;
    ftype_e            ftype;
  } head_flit_t;

  typedef struct packed {
    logic [PL_W-1:0] data;
    ftype_e          ftype;
  } body_flit_t;

endpackage

// File: rtl/ni_route_packer_table.sv
// Source-route table: one route per destination, synchronous write, combinational read.
// A read in the same cycle as a write to that entry returns the old route.
module ni_route_table
  import ni_route_packer_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [DEST_W-1:0] i_waddr,
  input  route_t            i_wdata,
  input  logic [DEST_W-1:0] i_raddr,
  output route_t            o_rdata_c
);

  route_t r_mem [DEST_NUM];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEST_NUM); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/ni_route_packer.sv
// Initiator NI packetizer: looks up the source route, emits header then body/tail
// flits toward the first switch under credit-based flow control.
module ni_route_packer
  import ni_route_packer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cfg_we,
  input  logic [DEST_W-1:0]     cfg_addr,
  input  logic [ROUTE_W-1:0]    cfg_route,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DEST_W-1:0]     req_dest,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [PL_W-1:0]       pl_data,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  input  logic                  credit_in,
  output logic                  credit_err
);

  state_e                r_state, w_state_nxt;
  logic [LEN_W-1:0]      r_len, w_len_nxt;
  logic [LEN_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [FLIT_WIDTH-1:0] r_flit, w_flit_nxt;
  logic                  r_flit_valid, w_flit_valid_nxt;
  logic [CRED_W-1:0]     r_credits;
  logic                  r_credit_err;
  logic                  r_alive;
  logic                  w_has_credit;
  logic                  w_send;
  route_t                w_route;
  head_flit_t            w_head;
  body_flit_t            w_body;

  ni_route_table u_table (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_we      (cfg_we),
    .i_waddr   (cfg_addr),
    .i_wdata   (route_t'(cfg_route)),
    .i_raddr   (req_dest),
    .o_rdata_c (w_route)
  );

  // Handshakes stay low in the first cycle after reset release.
  assign w_has_credit = r_alive && (r_credits != CRED_W'(0));
  assign w_cnt_inc    = r_cnt + LEN_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_flit       <= '0;
      r_flit_valid <= 1'b0;
      r_alive      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_cnt        <= w_cnt_nxt;
      r_flit       <= w_flit_nxt;
      r_flit_valid <= w_flit_valid_nxt;
      r_alive      <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len;
    w_cnt_nxt        = r_cnt;
    w_flit_nxt       = r_flit;
    w_flit_valid_nxt = 1'b0;
    w_send           = 1'b0;
    req_ready        = 1'b0;
    pl_ready         = 1'b0;

    w_head       = '0;
    w_head.len   = req_len;
    w_head.route = w_route;
    w_head.ftype = (req_len == LEN_W'(0)) ? FT_HEADTAIL : FT_HEAD;

    w_body.data  = pl_data;
    w_body.ftype = (w_cnt_inc == r_len) ? FT_TAIL : FT_BODY;

    case (r_state)
      ST_IDLE: begin
        req_ready = w_has_credit;
        if (req_valid && w_has_credit) begin
          w_send           = 1'b1;
          w_flit_nxt       = w_head;
          w_flit_valid_nxt = 1'b1;
          w_len_nxt        = req_len;
          w_cnt_nxt        = '0;
          if (req_len != LEN_W'(0)) begin
            w_state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        pl_ready = w_has_credit;
        if (pl_valid && w_has_credit) begin
          w_send           = 1'b1;
          w_flit_nxt       = w_body;
          w_flit_valid_nxt = 1'b1;
          w_cnt_nxt        = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A send and a returned credit in the same cycle cancel out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_credits    <= CRED_W'(CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      case ({w_send, credit_in})
        2'b10: r_credits <= r_credits - CRED_W'(1);
        2'b01: begin
          if (r_credits == CRED_W'(CREDITS)) begin
            r_credit_err <= 1'b1;
          end else begin
            r_credits <= r_credits + CRED_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign flit_out   = r_flit;
  assign flit_valid = r_flit_valid;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_ni_route_packer.sv
// Directed bench for ni_route_packer: expected flits queued when stimulus is
// driven, popped and compared as the DUT emits them.
module tb_ni_route_packer;
  import ni_route_packer_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [11:0] cfg_route = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_dest = '0;
  logic [3:0]  req_len = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [29:0] pl_data = '0;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic        credit_in = 1'b0;
  logic        credit_err;

  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  ni_route_packer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_route  (cfg_route),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest   (req_dest),
    .req_len    (req_len),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_data    (pl_data),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .credit_in  (credit_in),
    .credit_err (credit_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [11:0] route, input logic [3:0] len);
    return {14'd0, len, route, (len == 4'd0) ? 2'b11 : 2'b10};
  endfunction

  // Flit monitor: every emitted flit must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n && flit_valid) begin
      check("flit_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("flit", flit_out, exp_q.pop_front());
    end
  end

  task automatic cfg_wr(input logic [2:0] a, input logic [11:0] r);
    cfg_we = 1'b1; cfg_addr = a; cfg_route = r;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic req(input logic [2:0] dest, input logic [3:0] len, input logic [11:0] route);
    int w = 0;
    req_valid = 1'b1; req_dest = dest; req_len = len;
    while (!req_ready && w < 50) begin @(negedge clock); w++; end
    check("req_accept_in_time", 32'(w < 50), 32'd1);
    if (w < 50) exp_q.push_back(hdr(route, len));
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic pay(input logic [29:0] d, input bit last, output int waited);
    waited = 0;
    pl_valid = 1'b1; pl_data = d;
    while (!pl_ready && waited < 50) begin @(negedge clock); waited++; end
    check("pl_accept_in_time", 32'(waited < 50), 32'd1);
    if (waited < 50) exp_q.push_back({d, last ? 2'b01 : 2'b00});
    @(negedge clock);
  endtask

  task automatic pulse_credit();
    credit_in = 1'b1;
    @(negedge clock);
    credit_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(negedge clock);
    check("rst_flit_valid", 32'(flit_valid), 32'd0);
    check("rst_flit_out", flit_out, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_pl_ready", 32'(pl_ready), 32'd0);
    check("rst_credit_err", 32'(credit_err), 32'd0);
    check("rst_credits", 32'(dut.r_credits), 32'd4);
    reset_n = 1'b1;
    check("ready_at_release", 32'(req_ready), 32'd0);
    @(negedge clock);
    check("ready_after_release", 32'(req_ready), 32'd1);

    // Single-flit packet
    cfg_wr(3'd5, 12'hA6C);
    req(3'd5, 4'd0, 12'hA6C);
    check("credits_after_headtail", 32'(dut.r_credits), 32'd3);
    pulse_credit();
    check("credits_refilled", 32'(dut.r_credits), 32'd4);

    // len=3 back-to-back payload
    req(3'd5, 4'd3, 12'hA6C);
    pay(30'h1, 1'b0, w); check("body1_no_wait", 32'(w), 32'd0);
    pay(30'h2, 1'b0, w); check("body2_no_wait", 32'(w), 32'd0);
    pay(30'h3, 1'b1, w); check("tail_no_wait", 32'(w), 32'd0);
    pl_valid = 1'b0;
    check("credits_exhausted", 32'(dut.r_credits), 32'd0);
    check("req_blocked_no_credit", 32'(req_ready), 32'd0);
    repeat (4) pulse_credit();
    check("credits_back_to_4", 32'(dut.r_credits), 32'd4);

    // Overflow is sticky and saturates
    pulse_credit();
    check("credit_err_set", 32'(credit_err), 32'd1);
    check("credits_saturated", 32'(dut.r_credits), 32'd4);

    // len=7 with no credits returned: only 4 flits go out
    req(3'd5, 4'd7, 12'hA6C);
    for (int i = 1; i <= 3; i++) pay(30'(i + 16), 1'b0, w);
    check("pl_blocked", 32'(pl_ready), 32'd0);
    repeat (3) @(negedge clock);
    check("pl_still_blocked", 32'(pl_ready), 32'd0);
    check("no_flit_while_blocked", 32'(flit_valid), 32'd0);
    for (int i = 4; i <= 7; i++) begin
      pulse_credit();
      pay(30'(i + 16), i == 7, w);
      check("released_one_flit", 32'(w), 32'd0);
      check("blocked_again", 32'(pl_ready), 32'd0);
    end
    pl_valid = 1'b0;

    // Send and credit return in the same cycle
    pulse_credit();
    pulse_credit();
    check("credits_two", 32'(dut.r_credits), 32'd2);
    check("ready_for_combo", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_dest = 3'd5; req_len = 4'd0; credit_in = 1'b1;
    exp_q.push_back(hdr(12'hA6C, 4'd0));
    @(negedge clock);
    req_valid = 1'b0; credit_in = 1'b0;
    check("credits_unchanged", 32'(dut.r_credits), 32'd2);
    check("credit_err_still_set", 32'(credit_err), 32'd1);
    pulse_credit();
    pulse_credit();

    // Reset after the second flit of a len=3 packet
    req(3'd5, 4'd3, 12'hA6C);
    pay(30'h11, 1'b0, w);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_flit_valid", 32'(flit_valid), 32'd0);
    check("midreset_credits", 32'(dut.r_credits), 32'd4);
    check("midreset_credit_err", 32'(credit_err), 32'd0);
    check("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
    pl_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    // Route table was cleared by reset
    req(3'd5, 4'd1, 12'h000);
    pay(30'h22, 1'b1, w);
    pl_valid = 1'b0;

    // Same-cycle write to the entry being read latches the old route
    cfg_wr(3'd2, 12'h123);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_route = 12'h456;
    req(3'd2, 4'd0, 12'h123);
    cfg_we = 1'b0;
    req(3'd2, 4'd0, 12'h456);

    repeat (3) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ni_route_packer.md
Name: ni_route_packer

Overview:
- Initiator-side network-interface packetizer for the source-routed NoC. It is the injecting end of the path whose switches consume route bits hop by hop.
- Accepts a transaction (destination + payload length), looks up the source route in a programmable table, and emits a header flit followed by body/tail flits toward the first switch.
- Places the first-hop output-port selector in the lowest L_SW_OUT bits of the route field, so each switch can strip it and shift the remainder down.
- Output flow control is credit-based.

Parameters:
- FLIT_WIDTH, 32, flit width in bits
- L_SW_OUT, 2, route bits consumed per hop
- DEST_NUM, 8, number of route-table entries (destinations)
- DEST_W, 3, destination index width, clog2(DEST_NUM)
- LEN_W, 4, payload-length field width; 0..15 body flits
- CREDITS, 4, downstream buffer depth; credit counter reset value

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  route-table write strobe
- cfg_addr  in  DEST_W  route-table entry index
- cfg_route  in  `ROUTEWD  route written to the entry
- req_valid  in  1  transaction request valid
- req_ready  out  1  request accepted this cycle
- req_dest  in  DEST_W  destination index
- req_len  in  LEN_W  number of payload flits
- pl_valid  in  1  payload word valid
- pl_ready  out  1  payload word consumed this cycle
- pl_data  in  FLIT_WIDTH-`FTYPEWD  payload word
- flit_out  out  FLIT_WIDTH  registered flit to switch
- flit_valid  out  1  flit_out valid this cycle
- credit_in  in  1  one downstream buffer slot freed
- credit_err  out  1  sticky: credit overflow observed

Behaviour:
- Reset values: flit_out=0, flit_valid=0, req_ready=0, pl_ready=0, credit_err=0, credit counter=CREDITS, route table all zero, FSM=IDLE. Reset is asynchronous and may arrive mid-packet; the partial packet is dropped.
- Flit type field [`FTYPEWD-1:0] encodings: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEADTAIL=2'b11.
- Header flit layout:
  - [1:0] type
  - [`ROUTEWD+1:2] route as read from the table; hop 0 is in the lowest L_SW_OUT bits
  - next LEN_W bits: req_len
  - remaining bits: 0
- Body/tail flit layout: [1:0] type, upper bits = pl_data.
- FSM:
  - IDLE: req_ready=1 when credits>0 (combinational).
    - On req_valid&&req_ready, latch the route (table read of req_dest) and len.
    - Drive the header on the next edge: type HEAD, or HEADTAIL if len=0.
    - Go to IDLE if len=0, otherwise PAYLOAD.
  - PAYLOAD: pl_ready=1 when credits>0.
    - Each pl_valid&&pl_ready registers one flit.
    - The last flit (count==len) has type TAIL and returns the FSM to IDLE; earlier flits have type BODY.
- Latency: request accepted at edge N -> header flit_valid during cycle N+1. Payload word accepted at edge M -> flit at M+1. Back-to-back packets are allowed; there are no bubbles when credits and inputs are available.
- flit_valid is high exactly one cycle per flit. flit_out holds its last value when flit_valid=0.
- Credits:
  - Decrement per flit sent; increment per credit_in.
  - Both in the same cycle: counter unchanged.
  - At 0: nothing is accepted (req_ready and pl_ready low).
  - credit_in with counter already at CREDITS (and no send): counter saturates and credit_err sets, cleared only by reset.
- Route table:
  - Synchronous write on cfg_we. Read is combinational.
  - Write to the entry being read in the acceptance cycle: the old value is latched.
  - Writes during a packet do not affect the in-flight route.

Decomposition:
- Shared include noc_parameters.v supplies `FTYPEWD and `ROUTEWD.
- Add to the same shared definitions: the four flit-type encodings and the header length-field offset (`FTYPEWD+`ROUTEWD).
- One natural sub-module: ni_route_table (DEST_NUM x `ROUTEWD register file, sync write, async read).

Test Plan:
- Reset with CREDITS=4 -> flit_valid=0, req_ready=1 one cycle after reset_n rises, credit_err=0.
- Program entry 5 = 12'hA6C; request dest=5, len=0 -> one flit, type 2'b11, route field 12'hA6C, bits[1:0]=11, length field 0; credits drop to 3.
- Request dest=5, len=3 with payload 30'h1, 30'h2, 30'h3 -> flit types HEAD, BODY, BODY, TAIL on consecutive cycles; payload in bits[31:2].
- No credit_in, CREDITS=4, len=7 packet -> exactly 4 flits sent, then pl_ready=0; each credit_in pulse releases exactly one further flit.
- credit_in pulsed with counter=4 and idle -> credit_err=1, counter stays 4. Send and credit_in in the same cycle -> counter unchanged.
- reset_n asserted after the 2nd flit of a len=3 packet -> flit_valid=0 immediately, counter=CREDITS; the next request starts with a fresh HEAD.
